// File: rtl/mux_sel_rr_arbiter_pkg.sv
// mux_sel_rr_arbiter_pkg
//   Shared types and constants for the round-robin mux-select arbiter.
//   - state_e  : arbiter FSM states (idle / a requester owns the mux)
//   - idx_t    : requester index, also the shared mux select width
//   - onehot4  : index -> one-hot grant vector
package mux_sel_rr_arbiter_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot4(input idx_t i);
        return NUM_REQ'(1) << i;
    endfunction

endpackage

// File: rtl/mux_sel_rr_arbiter_rr_pick4.sv
// rr_pick4
//   Combinational rotating priority scan over four requesters.
//   Ports:
//     req_i      [3:0] request vector
//     start_i    [1:0] index scanned first; scan order start, start+1, ... (mod 4)
//     excl_en_i        when high, requester excl_idx_i is never picked
//     excl_idx_i [1:0] requester to exclude
//     found_o          a winner exists
//     idx_o      [1:0] winning index (0 when found_o is low)
module rr_pick4
    import mux_sel_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  idx_t               start_i,
    input  logic               excl_en_i,
    input  idx_t               excl_idx_i,
    output logic               found_o,
    output idx_t               idx_o
);

    idx_t cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // idx_t arithmetic wraps naturally, giving the mod-4 rotation
            cand = start_i + idx_t'(k);
            if (!found_o && req_i[cand] && !(excl_en_i && (cand == excl_idx_i))) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// mux_sel_rr_arbiter
//   Round-robin arbiter owning the select of a shared 4:1, 3-bit mux.
//   A hold limit (MAX_HOLD cycles) preempts an owner when others wait.
//   All outputs are registered; no combinational path from req.
//   Ports:
//     clk      rising-edge clock
//     reset    synchronous, active-high reset
//     req      [3:0] level-sensitive requests, req[i] from requester i
//     sel      [1:0] shared mux select = index of current owner (held when idle)
//     grant    [3:0] one-hot grant, zero when idle
//     busy     high while a grant is active
//     timeout  one-cycle pulse on the first cycle of a grant won by preemption
module mux_sel_rr_arbiter
    import mux_sel_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req,
    output logic [IDX_W-1:0]    sel,
    output logic [NUM_REQ-1:0]  grant,
    output logic                busy,
    output logic                timeout
);

    if (MAX_HOLD == 0 || MAX_HOLD > 255 || (MAX_HOLD >> CNT_W) != 0) begin : g_bad_param
        $error("mux_sel_rr_arbiter: MAX_HOLD must be 1..255 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    state_e             state_q,   state_d;
    idx_t               sel_q,     sel_d;
    logic [NUM_REQ-1:0] grant_q,   grant_d;
    logic               busy_q,    busy_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    idx_t               ptr_q,     ptr_d;

    logic owner_req;
    logic others_req;
    logic at_max;
    logic rel_a;
    logic rel_b;
    idx_t pick_start;
    logic pick_found;
    idx_t pick_idx;

    assign owner_req  = req[sel_q];
    assign others_req = |(req & ~onehot4(sel_q));
    assign at_max     = (cnt_q == HOLD_MAX);

    // Owner dropping its request takes precedence over expiry, so a
    // simultaneous drop never produces a timeout pulse.
    assign rel_a = (state_q == ST_OWN) && !owner_req;
    assign rel_b = (state_q == ST_OWN) && owner_req && at_max && others_req;

    // Idle scans from the pointer; on release the scan starts just past the
    // owner so it is naturally last, and is excluded outright on preemption.
    assign pick_start = (state_q == ST_IDLE) ? ptr_q : sel_q + idx_t'(1);

    rr_pick4 u_pick (
        .req_i      (req),
        .start_i    (pick_start),
        .excl_en_i  (rel_b),
        .excl_idx_i (sel_q),
        .found_o    (pick_found),
        .idx_o      (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_OWN;
                    sel_d   = pick_idx;
                    grant_d = onehot4(pick_idx);
                    busy_d  = 1'b1;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_OWN: begin
                if (rel_a || rel_b) begin
                    ptr_d = sel_q + idx_t'(1);
                    if (pick_found) begin
                        sel_d     = pick_idx;
                        grant_d   = onehot4(pick_idx);
                        cnt_d     = CNT_W'(1);
                        timeout_d = rel_b;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                    end
                end else if (!at_max) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
        end
    end

    assign sel     = sel_q;
    assign grant   = grant_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// tb_mux_sel_rr_arbiter
//   Self-checking bench for mux_sel_rr_arbiter: a vector table, hand-written
//   multi-cycle sequences and a randomized run against a behavioural model.
module tb_mux_sel_rr_arbiter;

    localparam int unsigned MAXH = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = '0;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_sel_rr_arbiter #(
        .MAX_HOLD (MAXH),
        .CNT_W    (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .sel     (sel),
        .grant   (grant),
        .busy    (busy),
        .timeout (timeout)
    );

    // Behavioural model: owner index (-1 = idle), hold count, pointer.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_ptr   = 0;
    int m_sel   = 0;
    bit m_to    = 1'b0;

    task automatic model_step(input bit rst, input logic [3:0] r);
        bit found;
        bit preempt;
        int start;
        int c;
        int win;
        found   = 1'b0;
        preempt = 1'b0;
        win     = 0;
        m_to    = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_cnt   = 0;
            m_ptr   = 0;
            m_sel   = 0;
            return;
        end
        if (m_owner < 0) begin
            start = m_ptr;
        end else begin
            preempt = r[m_owner] && (m_cnt == MAXH) && ((r & ~(4'b0001 << m_owner)) != 4'b0000);
            if (r[m_owner] && !preempt) begin
                if (m_cnt < MAXH) m_cnt = m_cnt + 1;
                return;
            end
            m_ptr = (m_owner + 1) % 4;
            start = (m_owner + 1) % 4;
        end
        for (int k = 0; k < 4; k++) begin
            c = (start + k) % 4;
            if (!found && r[c] && !(preempt && c == m_owner)) begin
                found = 1'b1;
                win   = c;
            end
        end
        if (found) begin
            m_owner = win;
            m_sel   = win;
            m_cnt   = 1;
            m_to    = preempt;
        end else begin
            m_owner = -1;
        end
    endtask

    function automatic logic [3:0] m_grant();
        return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    endfunction

    task automatic chk(input string name, input logic [3:0] eg, input logic [1:0] es,
                       input logic eb, input logic et);
        checks++;
        if (grant !== eg || sel !== es || busy !== eb || timeout !== et) begin
            errors++;
            $display("FAIL %s: got grant=%b sel=%0d busy=%b timeout=%b, want grant=%b sel=%0d busy=%b timeout=%b",
                     name, grant, sel, busy, timeout, eg, es, eb, et);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic cyc(input bit rst, input logic [3:0] r);
        @(negedge clk);
        reset = rst;
        req   = r;
        model_step(rst, r);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] rq;
        logic [3:0] eg;
        logic [1:0] es;
        logic       eb;
        logic       et;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [3:0] r;
        bit         rr;

        // Single request, release, pointer advance; then full round robin.
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1, 1'b0};

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].rst, tbl[i].rq);
            chk($sformatf("table[%0d]", i), tbl[i].eg, tbl[i].es, tbl[i].eb, tbl[i].et);
        end

        // Contention between 1 and 3: hold limit forces alternation.
        cyc(1'b1, 4'b0000);
        for (int i = 1; i <= 17; i++) begin
            cyc(1'b0, 4'b1010);
            if (i <= 8)
                chk($sformatf("hold1[%0d]", i), 4'b0010, 2'd1, 1'b1, 1'b0);
            else if (i <= 16)
                chk($sformatf("hold3[%0d]", i), 4'b1000, 2'd3, 1'b1, (i == 9));
            else
                chk("back_to_1", 4'b0010, 2'd1, 1'b1, 1'b1);
        end

        // Lone requester past the limit keeps the grant, no timeout.
        cyc(1'b1, 4'b0000);
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, 4'b0100);
            chk($sformatf("solo2[%0d]", i), 4'b0100, 2'd2, 1'b1, 1'b0);
        end

        // Reset mid-grant, pointer restarts at 0.
        cyc(1'b1, 4'b0000);
        cyc(1'b0, 4'b0100);
        chk("pre_grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
        cyc(1'b0, 4'b0000);
        chk("idle_sel_hold", 4'b0000, 2'd2, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 4'b0010);
            chk($sformatf("grant1[%0d]", i), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        cyc(1'b1, 4'b0010);
        chk("rst_mid_grant", 4'b0000, 2'd0, 1'b0, 1'b0);
        cyc(1'b0, 4'b1100);
        chk("ptr_restart", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Owner drops exactly when the count reaches the limit: no timeout.
        cyc(1'b1, 4'b0000);
        cyc(1'b0, 4'b0100);
        chk("own2_first", 4'b0100, 2'd2, 1'b1, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            cyc(1'b0, 4'b0101);
            chk($sformatf("own2[%0d]", i), 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        cyc(1'b0, 4'b0001);
        chk("drop_at_max", 4'b0001, 2'd0, 1'b1, 1'b0);
        cyc(1'b0, 4'b0001);
        chk("after_drop", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Randomized traffic with sticky requests and rare resets.
        cyc(1'b1, 4'b0000);
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            rr = ($urandom_range(199) == 0);
            cyc(rr, r);
            chk("random", m_grant(), 2'(m_sel), (m_owner >= 0), m_to);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_sel_rr_arbiter.md
Name: mux_sel_rr_arbiter

Overview:
Round-robin arbiter that shares one 4-input, 3-bit datapath mux between four requesters. It produces the registered 2-bit select for the shared 4-to-1 mux, plus a one-hot grant back to the requesters. A hold timeout prevents any single requester from monopolising the mux. It sits between the requesting units and the shared 3-bit mux, and is the only driver of that mux's select input.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one owner may hold the grant; legal range 1..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request vector; req[i] from requester i, level-sensitive.
- sel  output  2  select driven to the shared mux; equals the index of the current owner.
- grant  output  4  one-hot grant; all zeros when idle.
- busy  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when the owner is preempted by MAX_HOLD expiry.

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: sel=2'b00, grant=4'b0000, busy=0, timeout=0, hold counter=0, priority pointer ptr=2'd0 (requester 0 is highest priority after reset).
- Reset asserted mid-grant overrides everything. The grant drops on the next edge with no timeout pulse.
- All outputs are registered; there are no combinational paths from req to any output.
- States:
  - IDLE: grant=0, busy=0. On any req bit set, the winner is the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4). Next cycle: state=OWN, grant=onehot(winner), sel=winner, counter=1. Latency from req to grant is 1 cycle.
  - OWN: busy=1. sel and grant stay stable while req[sel]=1 and counter<MAX_HOLD. Counter increments each cycle; it saturates and never wraps.
- Release from OWN happens when either:
  - (a) req[sel]=0, or
  - (b) counter==MAX_HOLD and some other req bit is set.
- On release:
  - ptr := sel+1 (mod 4).
  - Re-arbitrate in the same cycle over req, starting from sel+1. The current owner is scanned last; on cause (b) it is excluded entirely.
  - If there is a winner, go directly to OWN with the new grant next cycle. There is no idle bubble, and counter=1.
  - If there is no winner, go to IDLE.
- Cause (b) asserts timeout for exactly the first cycle of the new grant.
- If counter==MAX_HOLD and no other requester is waiting, the owner keeps the grant, counter holds at MAX_HOLD, and there is no timeout.
- MAX_HOLD=1: every owner yields after 1 cycle whenever contention exists.
- Invariants:
  - grant is always zero or one-hot.
  - When grant is nonzero, sel==index(grant).
  - sel changes only on a grant change.
  - When idle, sel holds its last value and does not return to 0.
- Simultaneous events: owner dropping req in the same cycle as timeout expiry counts as cause (a), with no timeout pulse.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_OWN) and requester index width (2).
- One natural sub-module, rr_pick4: combinational priority scan. Inputs are req[3:0], start[1:0] and an exclude-enable/index; outputs are found and idx[1:0].
- The top level holds the FSM, counter, pointer and output registers, and instantiates rr_pick4 once.

Test Plan:
- Reset then req=4'b0100 held → 1 cycle later grant=4'b0100, sel=2, busy=1. Drop req → grant=0 next cycle, sel stays 2, ptr=3.
- After reset, req=4'b1111 with each owner dropping req after 2 cycles → grant order 0,1,2,3,0 with no idle cycles between owners.
- MAX_HOLD=8, req[1] and req[3] held continuously → owner 1 for 8 cycles, then owner 3 with timeout=1 for one cycle, then 3 holds 8 cycles and grant returns to 1.
- req[2] alone held for 20 cycles (MAX_HOLD=8) → grant stays 4'b0100 throughout, timeout never pulses, counter saturates at 8.
- Reset asserted on cycle 3 of a grant → next edge grant=0, sel=0, busy=0, timeout=0. Then req=4'b1000 → grant=4'b1000 (ptr restarted at 0).
- Owner drops req in the exact cycle counter reaches MAX_HOLD while req[0] is waiting → handoff to 0 with timeout=0.
